// File: rtl/pwm_ramp_pkg.sv
// rtl/pwm_ramp_pkg.sv - shared types, constants and step arithmetic for the PWM ramp sequencer
package pwm_ramp_pkg;

    localparam int PWM_N  = 8;
    localparam int PWM_DW = 8;

    localparam logic [PWM_N-1:0] PWM_RESET_PERIOD = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        RAMP  = 2'd2
    } ramp_state_t;

    // One step from cur toward tgt; the N+1-bit difference clamps the result at tgt instead of wrapping.
    function automatic logic [PWM_N-1:0] step_toward(input logic [PWM_N-1:0] cur,
                                                     input logic [PWM_N-1:0] tgt,
                                                     input logic [PWM_N-1:0] stp);
        logic [PWM_N:0] w_diff;
        if (tgt >= cur) begin
            w_diff = {1'b0, tgt} - {1'b0, cur};
            return (w_diff <= {1'b0, stp}) ? tgt : cur + stp;
        end else begin
            w_diff = {1'b0, cur} - {1'b0, tgt};
            return (w_diff <= {1'b0, stp}) ? tgt : cur - stp;
        end
    endfunction

endpackage

// File: rtl/pwm_ramp_if.sv
// rtl/pwm_ramp_if.sv - ramp command handshake bundle
interface pwm_ramp_if #(
    parameter int N  = 8,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_target;
    logic [N-1:0]  cmd_step;
    logic [DW-1:0] cmd_frames;
    logic [N-1:0]  cmd_period;

    modport master (
        output cmd_valid, cmd_target, cmd_step, cmd_frames, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_step, cmd_frames, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl_frame_timer.sv
// rtl/pwm_ramp_ctrl_frame_timer.sv - PWM frame counter producing the end-of-frame tick
module pwm_frame_timer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [N-1:0] period,
    output logic         frame_tick
);
    logic [N-1:0] r_fcnt;
    logic         w_wrap;

    assign w_wrap     = (r_fcnt == period);
    assign frame_tick = w_wrap & clr_n;

    // Count 0..period and wrap; a period change lands on the wrap so the next frame uses it.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_fcnt <= '0;
        end else if (w_wrap) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + N'(1);
        end
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - frame-aligned duty ramp sequencer for pwmN; optional PWM_RAMP_IRQ_EN adds irq/irq_clr
module pwm_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int N  = PWM_N,
    parameter int DW = PWM_DW
) (
    input  logic         clk,
    input  logic         clr_n,
    pwm_ramp_if.slave    cmd,
    input  logic         abort,
    output logic [N-1:0] duty,
    output logic [N-1:0] period,
    output logic         frame_tick,
    output logic         busy,
    output logic         done
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic         irq,
    input  logic         irq_clr
`endif
);
    ramp_state_t   r_state;
    logic [N-1:0]  r_target;
    logic [N-1:0]  r_step;
    logic [DW-1:0] r_frames;
    logic [N-1:0]  r_new_period;
    logic [DW-1:0] r_dwell;
    logic [N-1:0]  r_duty;
    logic [N-1:0]  r_period;
    logic          r_done;
    logic          w_tick;
    logic [N-1:0]  w_next;
    logic          w_abort;

    pwm_frame_timer #(.N(N)) u_timer (
        .clk        (clk),
        .clr_n      (clr_n),
        .period     (r_period),
        .frame_tick (w_tick)
    );

    assign w_next        = step_toward(r_duty, r_target, r_step);
    assign w_abort       = abort && (r_state != IDLE);
    assign cmd.cmd_ready = (r_state == IDLE);
    assign duty          = r_duty;
    assign period        = r_period;
    assign frame_tick    = w_tick;
    assign busy          = (r_state != IDLE) & clr_n;
    assign done          = r_done & clr_n;

    // Command latch, frame-aligned period/duty updates and dwell counting; abort wins over a same-cycle step.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state      <= IDLE;
            r_target     <= '0;
            r_step       <= '0;
            r_frames     <= '0;
            r_new_period <= '0;
            r_dwell      <= '0;
            r_duty       <= '0;
            r_period     <= PWM_RESET_PERIOD;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        r_target     <= cmd.cmd_target;
                        r_step       <= (cmd.cmd_step == '0) ? N'(1) : cmd.cmd_step;
                        r_frames     <= (cmd.cmd_frames == '0) ? DW'(1) : cmd.cmd_frames;
                        r_new_period <= cmd.cmd_period;
                        r_state      <= APPLY;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        r_period <= r_new_period;
                        r_dwell  <= r_frames - DW'(1);
                        if (r_duty == r_target) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        if (r_dwell != '0) begin
                            r_dwell <= r_dwell - DW'(1);
                        end else begin
                            r_duty  <= w_next;
                            r_dwell <= r_frames - DW'(1);
                            if (w_next == r_target) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    logic r_irq;
    assign irq = r_irq;

    // Sticky completion/abort flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_irq <= 1'b0;
        end else if (r_done || w_abort) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;
    logic       clk = 1'b0;
    logic       clr_n;
    logic       abort;
    logic [7:0] duty;
    logic [7:0] period;
    logic       frame_tick;
    logic       busy;
    logic       done;
`ifdef PWM_RAMP_IRQ_EN
    logic       irq;
    logic       irq_clr;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int model_duty  = 0;

    always #5 clk = ~clk;

    pwm_ramp_if #(.N(8), .DW(8)) cmd_if ();

    pwm_ramp_ctrl #(.N(8), .DW(8)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .cmd        (cmd_if),
        .abort      (abort),
        .duty       (duty),
        .period     (period),
        .frame_tick (frame_tick),
        .busy       (busy),
        .done       (done)
`ifdef PWM_RAMP_IRQ_EN
        ,
        .irq        (irq),
        .irq_clr    (irq_clr)
`endif
    );

    task automatic push_model(input int tgt, input int stp);
        int s;
        s = (stp == 0) ? 1 : stp;
        while (model_duty != tgt) begin
            if (tgt > model_duty) model_duty = (tgt - model_duty <= s) ? tgt : model_duty + s;
            else                  model_duty = (model_duty - tgt <= s) ? tgt : model_duty - s;
            exp_q.push_back(model_duty);
        end
    endtask

    task automatic issue(input int tgt, input int stp, input int frm, input int per);
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_target = tgt[7:0];
        cmd_if.cmd_step   = stp[7:0];
        cmd_if.cmd_frames = frm[7:0];
        cmd_if.cmd_period = per[7:0];
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic watch(input int budget, input int interval, input int abort_at,
                         input bit inject, output int done_cnt);
        int         last_t;
        int         e;
        bit         fin;
        logic [7:0] prev;
        last_t   = -1;
        fin      = 1'b0;
        prev     = duty;
        done_cnt = 0;
        for (int t = 0; t < budget && !fin; t++) begin
            @(negedge clk);
            if (duty !== prev) begin
                vectors++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                if (e < 0 || duty !== e[7:0]) begin
                    miscompares++;
                    $display("FAIL sb_duty: got %0d want %0d", duty, e);
                end
                if (last_t >= 0) begin
                    vectors++;
                    if (t - last_t != interval) begin
                        miscompares++;
                        $display("FAIL step_interval: got %0d want %0d", t - last_t, interval);
                    end
                end
                last_t = t;
                prev   = duty;
            end
            if (done === 1'b1) begin
                done_cnt++;
                fin = 1'b1;
                vectors++;
                if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL done_state: busy=%b ready=%b want busy=0 ready=1", busy, cmd_if.cmd_ready);
                end
            end else if (abort_at >= 0 && duty === abort_at[7:0]) begin
                abort = 1'b1;
                fin   = 1'b1;
            end
            if (inject) begin
                if (t == 300) begin
                    cmd_if.cmd_valid  = 1'b1;
                    cmd_if.cmd_target = 8'd100;
                    cmd_if.cmd_step   = 8'd50;
                    cmd_if.cmd_frames = 8'd1;
                    cmd_if.cmd_period = 8'd7;
                end
                if (t == 305) begin
                    vectors++;
                    if (cmd_if.cmd_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL ready_in_ramp: got %b want 0", cmd_if.cmd_ready);
                    end
                end
                if (t == 310) cmd_if.cmd_valid = 1'b0;
            end
        end
        cmd_if.cmd_valid = 1'b0;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL watch_timeout: got no done/abort point want one within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        int k;
        clr_n            = 1'b0;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
`ifdef PWM_RAMP_IRQ_EN
        irq_clr          = 1'b0;
`endif
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_low_outputs: busy=%b done=%b tick=%b want 0 0 0", busy, done, frame_tick);
        end
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        #1;
        vectors++;
        if (duty !== 8'd0 || period !== 8'd255 || cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: duty=%0d period=%0d ready=%b busy=%b want 0 255 1 0",
                     duty, period, cmd_if.cmd_ready, busy);
        end
        k = 0;
        while (frame_tick !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (k != 255) begin
            miscompares++;
            $display("FAIL first_tick: got %0d cycles want 255", k);
        end
    endtask

    task automatic test_ramp_up();
        int dc;
        issue(10, 2, 1, 255);
        vectors++;
        if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_state: busy=%b ready=%b want 1 0", busy, cmd_if.cmd_ready);
        end
        push_model(10, 2);
        watch(3000, 256, -1, 1'b0, dc);
        @(negedge clk);
        vectors++;
        if (dc != 1 || exp_q.size() != 0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ramp_up_end: done_cnt=%0d left=%0d done_now=%b want 1 0 0", dc, exp_q.size(), done);
        end
    endtask

    task automatic test_saturation();
        int dc;
        issue(255, 100, 2, 255);
        push_model(255, 100);
        watch(4000, 512, -1, 1'b0, dc);
        vectors++;
        if (dc != 1 || exp_q.size() != 0 || duty !== 8'd255) begin
            miscompares++;
            $display("FAIL saturation_end: done_cnt=%0d left=%0d duty=%0d want 1 0 255", dc, exp_q.size(), duty);
        end
    endtask

    task automatic test_ramp_down();
        int dc;
        int ticks;
        issue(0, 128, 1, 3);
        push_model(0, 128);
        watch(3000, 4, -1, 1'b0, dc);
        vectors++;
        if (dc != 1 || exp_q.size() != 0 || period !== 8'd3) begin
            miscompares++;
            $display("FAIL ramp_down_end: done_cnt=%0d left=%0d period=%0d want 1 0 3", dc, exp_q.size(), period);
        end
        ticks = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        vectors++;
        if (ticks != 10) begin
            miscompares++;
            $display("FAIL tick_rate: got %0d ticks in 40 cycles want 10", ticks);
        end
    endtask

    task automatic test_abort();
        int dc;
        bit held;
        issue(200, 1, 1, 255);
        push_model(200, 1);
        watch(3000, 256, 5, 1'b0, dc);
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || duty !== 8'd5 || done !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || dc != 0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b duty=%0d done=%b ready=%b want 0 5 0 1",
                     busy, duty, done, cmd_if.cmd_ready);
        end
        exp_q.delete();
        model_duty = 5;
`ifdef PWM_RAMP_IRQ_EN
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_set: got %b want 1", irq);
        end
`endif
        held = 1'b1;
        repeat (600) begin
            @(negedge clk);
            if (duty !== 8'd5 || done !== 1'b0 || busy !== 1'b0) held = 1'b0;
        end
        vectors++;
        if (!held) begin
            miscompares++;
            $display("FAIL abort_hold: got duty=%0d done=%b want duty 5 with no done", duty, done);
        end
`ifdef PWM_RAMP_IRQ_EN
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: got %b want 0", irq);
        end
`endif
    endtask

    task automatic test_busy_ignored();
        int dc;
        issue(8, 1, 1, 255);
        push_model(8, 1);
        watch(3000, 256, -1, 1'b1, dc);
        vectors++;
        if (dc != 1 || exp_q.size() != 0 || period !== 8'd255 || duty !== 8'd8) begin
            miscompares++;
            $display("FAIL busy_ignored: done_cnt=%0d left=%0d period=%0d duty=%0d want 1 0 255 8",
                     dc, exp_q.size(), period, duty);
        end
    endtask

    task automatic test_null_ramp();
        int dc;
        issue(8, 3, 1, 255);
        watch(600, 0, -1, 1'b0, dc);
        vectors++;
        if (dc != 1 || duty !== 8'd8) begin
            miscompares++;
            $display("FAIL null_ramp: done_cnt=%0d duty=%0d want 1 8", dc, duty);
        end
    endtask

    task automatic test_reset_mid();
        int  k;
        bit  idle;
        issue(100, 1, 1, 15);
        k = 0;
        while (duty !== 8'd50 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (duty !== 8'd50) begin
            miscompares++;
            $display("FAIL reach_50: got %0d want 50", duty);
        end
        clr_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || frame_tick !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_low: busy=%b tick=%b done=%b want 0 0 0", busy, frame_tick, done);
        end
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        vectors++;
        if (duty !== 8'd0 || period !== 8'd255 || dut.u_timer.r_fcnt !== 8'd0 ||
            cmd_if.cmd_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: duty=%0d period=%0d fcnt=%0d ready=%b done=%b want 0 255 0 1 0",
                     duty, period, dut.u_timer.r_fcnt, cmd_if.cmd_ready, done);
        end
        model_duty = 0;
        idle = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || duty !== 8'd0) idle = 1'b0;
        end
        vectors++;
        if (!idle) begin
            miscompares++;
            $display("FAIL mid_reset_discard: busy=%b duty=%0d want 0 0", busy, duty);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_saturation();
        test_ramp_down();
        test_abort();
        test_busy_ignored();
        test_null_ramp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
